// File: rtl/cnt_run_ctrl.sv
// Run/pause/clear sequencer for the 16-bit display counter.
// Two raw push-buttons are synchronized, optionally debounced and edge-detected into one-cycle
// run/clear pulses that drive a four-state run controller. A prescaler divides the clock into a
// count tick. The counter's ce/pe/d inputs are driven from registers.
// Optional feature: define CNT_RUN_CTRL_DEBOUNCE_EN to insert a DB_CYCLES debounce filter
// between the synchronizers and the edge detectors.
module cnt_run_ctrl #(
    parameter int unsigned DIV       = 100000,
    parameter int unsigned DB_CYCLES = 20
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        btn_run_i,
    input  logic        btn_clr_i,
    input  logic [15:0] init_i,
    input  logic [15:0] lim_i,
    input  logic [15:0] cnt_i,
    output logic        ce_o,
    output logic        pe_o,
    output logic [15:0] d_o,
    output logic [1:0]  state_o,
    output logic        tick_o
);

    localparam int unsigned     PscW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PscW-1:0] PscMax = PscW'(DIV - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StDone  = 2'b11
    } state_e;

    // ---------------------------------------------------------------------------------------
    // Button input path; bit 0 = run, bit 1 = clear
    // ---------------------------------------------------------------------------------------
    logic [1:0] btn_raw;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] lvl;
    logic [1:0] prev_q;
    logic [1:0] pulse_q;
    logic       run_p;
    logic       clr_p;

    assign btn_raw = {btn_clr_i, btn_run_i};
    assign run_p   = pulse_q[0];
    assign clr_p   = pulse_q[1];

    // Two-flop synchronizer for both asynchronous buttons
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef CNT_RUN_CTRL_DEBOUNCE_EN
    localparam int unsigned    DbW   = $clog2(DB_CYCLES + 1);
    localparam logic [DbW-1:0] DbMax = DbW'(DB_CYCLES - 1);

    logic [1:0][DbW-1:0] db_cnt_q;
    logic [1:0][DbW-1:0] db_cnt_d;
    logic [1:0]          filt_q;
    logic [1:0]          filt_d;

    // Filtered level flips only after the synchronized level has differed for DB_CYCLES clocks;
    // any agreement in between restarts the count
    always_comb begin
        db_cnt_d = '0;
        filt_d   = filt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (db_cnt_q[i] == DbMax) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    // Debounce filter state
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            db_cnt_q <= '0;
            filt_q   <= '0;
        end else begin
            db_cnt_q <= db_cnt_d;
            filt_q   <= filt_d;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync2_q;

    // Filter removed; DB_CYCLES has no effect in this build
    if (DB_CYCLES == 0) begin : g_db_unused
    end
`endif

    // Registered rising-edge detector: one pulse per press, held buttons do not repeat
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            prev_q  <= '0;
            pulse_q <= '0;
        end else begin
            prev_q  <= lvl;
            pulse_q <= lvl & ~prev_q;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Run controller FSM
    // ---------------------------------------------------------------------------------------
    state_e state_q;
    state_e state_d;

    logic [PscW-1:0] psc_q;
    logic [PscW-1:0] psc_d;
    logic            tick_q;
    logic            tick_d;
    logic            ce_q;
    logic            ce_d;
    logic            pe_q;
    logic            pe_d;
    logic [15:0]     d_q;
    logic [15:0]     d_d;
    logic            at_lim;

    assign at_lim = (cnt_i == lim_i);

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clear beats everything, a run press beats a limit tick
    always_comb begin
        state_d = state_q;
        if (clr_p) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (run_p) state_d = StRun;
                end
                StRun: begin
                    if (run_p) begin
                        state_d = StPause;
                    end else if (tick_q && at_lim) begin
                        state_d = StDone;
                    end
                end
                StPause: begin
                    if (run_p) state_d = StRun;
                end
                StDone: begin
                    if (run_p) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Output and prescaler next values; everything leaves the block through a register
    always_comb begin
        ce_d   = 1'b0;
        pe_d   = clr_p;
        d_d    = d_q;
        tick_d = 1'b0;
        psc_d  = psc_q;
        if (clr_p) begin
            d_d   = init_i;
            psc_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Fresh run always starts a full prescaler period
                    if (run_p) psc_d = '0;
                end
                StRun: begin
                    // Prescaler advances even on the pausing cycle, so a tick there still wraps
                    if (psc_q == PscMax) begin
                        psc_d  = '0;
                        tick_d = 1'b1;
                    end else begin
                        psc_d = psc_q + PscW'(1);
                    end
                    ce_d = tick_q && !run_p && !at_lim;
                end
                StPause: begin
                    // Prescaler holds so resume finishes the partial period
                end
                StDone: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Output and prescaler registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            psc_q  <= '0;
            tick_q <= 1'b0;
            ce_q   <= 1'b0;
            pe_q   <= 1'b0;
            d_q    <= '0;
        end else begin
            psc_q  <= psc_d;
            tick_q <= tick_d;
            ce_q   <= ce_d;
            pe_q   <= pe_d;
            d_q    <= d_d;
        end
    end

    assign ce_o    = ce_q;
    assign pe_o    = pe_q;
    assign d_o     = d_q;
    assign tick_o  = tick_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_cnt_run_ctrl.sv
// Directed self-checking bench for cnt_run_ctrl with DIV=4, DB_CYCLES=3.
// A behavioural counter feeds cnt back: it loads d on pe and increments on ce.
module tb_cnt_run_ctrl;

    localparam int unsigned DIV = 4;
    localparam int unsigned DB  = 3;
`ifdef CNT_RUN_CTRL_DEBOUNCE_EN
    localparam int BL = 3 + DB;
`else
    localparam int BL = 3;
`endif
    // Offset that lines the clear edge up with a pending tick
    localparam int S4 = (BL == 3) ? 2 : 3;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;
    localparam logic [1:0] DONE  = 2'b11;

    logic        clk     = 1'b0;
    logic        rstn    = 1'b0;
    logic        btn_run = 1'b0;
    logic        btn_clr = 1'b0;
    logic [15:0] init_v  = '0;
    logic [15:0] lim_v   = '0;
    logic [15:0] cnt_m   = '0;
    logic        ce;
    logic        pe;
    logic [15:0] d;
    logic [1:0]  state;
    logic        tick;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned ce_log[$];
    int unsigned e;

    cnt_run_ctrl #(
        .DIV       (DIV),
        .DB_CYCLES (DB)
    ) dut (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .btn_run_i (btn_run),
        .btn_clr_i (btn_clr),
        .init_i    (init_v),
        .lim_i     (lim_v),
        .cnt_i     (cnt_m),
        .ce_o      (ce),
        .pe_o      (pe),
        .d_o       (d),
        .state_o   (state),
        .tick_o    (tick)
    );

    always #5 clk = ~clk;

    // Counter model and ce logger; an entry is the edge number after which ce was high
    always @(posedge clk) begin
        if (ce) ce_log.push_back(cyc);
        cyc <= cyc + 1;
        if (pe) cnt_m <= d;
        else if (ce) cnt_m <= cnt_m + 16'd1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned ce_at(input int i);
        return (i < ce_log.size()) ? ce_log[i] : 32'hFFFF_FFFF;
    endfunction

    // Press buttons; state must still be st_old one edge before the expected change
    task automatic press(input logic r, input logic c, input logic [1:0] st_old,
                         input logic [1:0] st_new, input string tag);
        btn_run = r;
        btn_clr = c;
        step(BL);
        check({tag, " hold"}, 32'(state), 32'(st_old));
        step(1);
        check(tag, 32'(state), 32'(st_new));
        btn_run = 1'b0;
        btn_clr = 1'b0;
    endtask

    initial begin
        // Reset
        step(2);
        check("rst state", 32'(state), 32'(IDLE));
        check("rst ce", 32'(ce), 0);
        check("rst pe", 32'(pe), 0);
        check("rst tick", 32'(tick), 0);
        check("rst d", 32'(d), 0);
        rstn = 1'b1;
        step(3);

        // Run to limit
        init_v = 16'h0000;
        lim_v  = 16'd5;
        press(1'b0, 1'b1, IDLE, IDLE, "T2 clr");
        check("T2 pe", 32'(pe), 1);
        check("T2 d", 32'(d), 0);
        step(1);
        check("T2 pe width", 32'(pe), 0);
        step(8);
        ce_log.delete();
        press(1'b1, 1'b0, IDLE, RUN, "T2 run");
        e = cyc;
        step(4);
        check("T2 tick", 32'(tick), 1);
        check("T2 ce early", 32'(ce), 0);
        step(1);
        check("T2 ce", 32'(ce), 1);
        check("T2 tick width", 32'(tick), 0);
        step(25);
        check("T2 ce count", ce_log.size(), 5);
        check("T2 first ce", ce_at(0), e + 5);
        for (int i = 1; i < 5; i++) check("T2 spacing", ce_at(i) - ce_at(i - 1), DIV);
        check("T2 cnt", 32'(cnt_m), 5);
        check("T2 state done", 32'(state), 32'(DONE));
        press(1'b1, 1'b0, DONE, IDLE, "T2 done->idle");

        // Pause / resume with prescaler held at 2
        step(8);
        lim_v = 16'd100;
        press(1'b0, 1'b1, IDLE, IDLE, "T3 clr");
        step(8);
        ce_log.delete();
        press(1'b1, 1'b0, IDLE, RUN, "T3 run");
        e = cyc;
        step(14 - 1 - BL);
        press(1'b1, 1'b0, RUN, PAUSE, "T3 pause");
        check("T3 ce before pause", ce_log.size(), 3);
        step(20);
        check("T3 ce paused", ce_log.size(), 3);
        check("T3 still paused", 32'(state), 32'(PAUSE));
        check("T3 cnt paused", 32'(cnt_m), 3);
        ce_log.delete();
        press(1'b1, 1'b0, PAUSE, RUN, "T3 resume");
        e = cyc;
        step(5);
        check("T3 ce after resume", ce_log.size(), 1);
        check("T3 resume ce time", ce_at(0), e + 3);

        // Clear and run pressed together while a tick is pending
        init_v = 16'h1234;
        step(S4);
        press(1'b1, 1'b1, RUN, IDLE, "T4 clr+run");
        check("T4 pe", 32'(pe), 1);
        check("T4 d", 32'(d), 32'h1234);
        check("T4 no ce", 32'(ce), 0);
        ce_log.delete();
        step(12);
        check("T4 ce after clr", ce_log.size(), 0);
        check("T4 cnt", 32'(cnt_m), 32'h1234);
        check("T4 state", 32'(state), 32'(IDLE));

        // Wrap through FFFF
        step(4);
        init_v = 16'hFFFE;
        lim_v  = 16'd1;
        press(1'b0, 1'b1, IDLE, IDLE, "T6 clr");
        check("T6 d", 32'(d), 32'hFFFE);
        step(4);
        ce_log.delete();
        press(1'b1, 1'b0, IDLE, RUN, "T6 run");
        e = cyc;
        step(25);
        check("T6 ce count", ce_log.size(), 3);
        check("T6 last ce", ce_at(2), e + 13);
        check("T6 cnt", 32'(cnt_m), 1);
        check("T6 state", 32'(state), 32'(DONE));
        press(1'b1, 1'b0, DONE, IDLE, "T6 done->idle");

        // Reset in the middle of a run
        step(6);
        init_v = 16'hABCD;
        lim_v  = 16'h0000;
        press(1'b0, 1'b1, IDLE, IDLE, "T1 clr");
        step(4);
        press(1'b1, 1'b0, IDLE, RUN, "T1 run");
        step(4);
        check("T1 tick pre", 32'(tick), 1);
        rstn = 1'b0;
        #2;
        check("T1 async state", 32'(state), 32'(IDLE));
        check("T1 async tick", 32'(tick), 0);
        check("T1 async d", 32'(d), 0);
        check("T1 async ce", 32'(ce), 0);
        check("T1 async pe", 32'(pe), 0);
        step(2);
        rstn = 1'b1;
        ce_log.delete();
        step(20);
        check("T1 no ce", ce_log.size(), 0);
        check("T1 idle", 32'(state), 32'(IDLE));

        // Short glitch and 5-cycle press
        btn_run = 1'b1;
        step(2);
        btn_run = 1'b0;
        step(12);
`ifdef CNT_RUN_CTRL_DEBOUNCE_EN
        check("T5 glitch", 32'(state), 32'(IDLE));
        btn_run = 1'b1;
        step(5);
        btn_run = 1'b0;
        step(1);
        check("T5 press k+5", 32'(state), 32'(IDLE));
        step(1);
        check("T5 press k+6", 32'(state), 32'(RUN));
`else
        check("T5 glitch", 32'(state), 32'(RUN));
        btn_run = 1'b1;
        step(3);
        check("T5 press k+2", 32'(state), 32'(RUN));
        step(1);
        check("T5 press k+3", 32'(state), 32'(PAUSE));
        step(1);
        btn_run = 1'b0;
`endif
        step(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
